// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter, one bit per clk cycle. Defining
//            UART_TX_FIFO_EN adds a 4-entry input FIFO for gapless frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       signal,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       signal_q, signal_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;

    logic       w_push;
    logic       w_load;
    logic [7:0] w_load_byte;

    assign w_push = data_valid & ready_q;

`ifdef UART_TX_FIFO_EN
    localparam int C_DEPTH = 4;

    logic [7:0] fifo_mem_q [C_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    // Popping in the last STOP cycle lets the next start bit follow directly.
    assign w_load      = (count_q != 3'd0) && ((state_q == IDLE) || (state_q == STOP));
    assign w_load_byte = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = w_load ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, w_push} - {2'b00, w_load};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= data_in;
        end
    end
`else
    assign w_load      = w_push;
    assign w_load_byte = data_in;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = START;
                    hold_d  = w_load_byte;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
            end
            DATA: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (w_load) begin
                    state_d = START;
                    hold_d  = w_load_byte;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered versions of what the next state implies.
        signal_d = 1'b1;
        if (state_d == START) begin
            signal_d = 1'b0;
        end else if (state_d == DATA) begin
            signal_d = hold_d[bit_cnt_d];
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP);
`ifdef UART_TX_FIFO_EN
        ready_d = (count_d != 3'(C_DEPTH));
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            hold_q    <= 8'h00;
            signal_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            signal_q  <= signal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign data_ready = ready_q;
    assign signal     = signal_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx against a frame-level model,
//            with a loopback receiver. Honours UART_TX_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, signal, busy, frame_done;

    uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal     (signal),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

`ifdef UART_TX_FIFO_EN
    localparam int EXP_PERIOD = 10;
`else
    localparam int EXP_PERIOD = 11;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model: m_pos is -1 when idle, else position 0..9 within the frame.
    int         m_pos       = -1;
    logic [7:0] m_cur       = 8'h00;
    logic [7:0] m_q[$];
    bit         m_after_rst = 1'b1;
    int         m_frames    = 0;
    logic [7:0] m_sent[$];

    bit         feed  = 1'b0;
    bit         churn = 1'b0;
    logic [7:0] tx_q[$];

    logic s_sig, s_busy, s_done, s_ready;
    bit   ready_low_seen = 1'b0;

    int         rx_pos   = -1;
    logic [7:0] rx_b     = 8'h00;
    int         rx_start = 0;
    logic [7:0] rx_q[$];
    int         rx_starts[$];

    bit exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready();
`ifdef UART_TX_FIFO_EN
        return !m_after_rst && (m_q.size() < 4);
`else
        return !m_after_rst && (m_pos < 0);
`endif
    endfunction

    function automatic bit m_sig();
        if (m_pos < 0 || m_pos == 9) return 1'b1;
        if (m_pos == 0) return 1'b0;
        return m_cur[m_pos-1];
    endfunction

    task automatic m_step(input bit rst, input bit v, input logic [7:0] d, input bit rdy);
        if (rst) begin
            m_pos = -1;
            m_q.delete();
            m_after_rst = 1'b1;
            return;
        end
        m_after_rst = 1'b0;
`ifdef UART_TX_FIFO_EN
        if (m_pos < 0 || m_pos == 9) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end else begin
                m_pos = -1;
            end
        end else begin
            m_pos++;
        end
        if (v && rdy) m_q.push_back(d);
`else
        if (m_pos < 0) begin
            if (v && rdy) begin
                m_cur = d;
                m_pos = 0;
            end
        end else if (m_pos == 9) begin
            m_pos = -1;
        end else begin
            m_pos++;
        end
`endif
    endtask

    // One clock: drive, sample and compare at negedge, then step the model.
    task automatic cycle();
        bit rdy;
        rdy = m_ready();
        if (feed) begin
            if (tx_q.size() > 0) begin
                data_valid = 1'b1;
                data_in    = (churn && !rdy) ? 8'($urandom) : tx_q[0];
            end else begin
                data_valid = 1'b0;
                if (churn) data_in = 8'($urandom);
            end
        end
        @(negedge clk);
        s_sig   = signal;
        s_busy  = busy;
        s_done  = frame_done;
        s_ready = data_ready;
        chk("signal",     s_sig,   m_sig());
        chk("busy",       s_busy,  m_pos >= 0);
        chk("frame_done", s_done,  m_pos == 9);
        chk("data_ready", s_ready, rdy);
        if (s_ready === 1'b0) ready_low_seen = 1'b1;
        if (m_pos == 9) begin
            m_frames++;
            m_sent.push_back(m_cur);
        end
        if (rx_pos < 0) begin
            if (s_sig === 1'b0) begin
                rx_pos   = 0;
                rx_start = cyc;
            end
        end else if (rx_pos < 8) begin
            rx_b[rx_pos] = s_sig;
            rx_pos++;
        end else begin
            chk("rx_stop_bit", s_sig, 1);
            rx_q.push_back(rx_b);
            rx_starts.push_back(rx_start);
            rx_pos = -1;
        end
        @(posedge clk);
        if (reset) rx_pos = -1;
        if (feed && data_valid && rdy && !reset) void'(tx_q.pop_front());
        m_step(reset, data_valid, data_in, rdy);
        cyc++;
        #1;
    endtask

    task automatic wait_frame(output logic [7:0] b, output int st);
        int n0;
        int k;
        n0 = rx_q.size();
        k  = 0;
        while (rx_q.size() == n0 && k < 40) begin
            cycle();
            k++;
        end
        chk("frame_arrived", rx_q.size() > n0, 1);
        if (rx_q.size() > n0) begin
            b  = rx_q[n0];
            st = rx_starts[n0];
        end else begin
            b  = 8'hxx;
            st = -1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1, b2;
        int         s1, s2;

        repeat (2) @(posedge clk);
        #1;
        m_step(1'b1, 1'b0, 8'h00, 1'b0);

        // Reset state
        cycle();
        chk("rst_signal", s_sig, 1);
        chk("rst_busy",   s_busy, 0);
        chk("rst_done",   s_done, 0);
        chk("rst_ready",  s_ready, 0);
        reset = 1'b0;
        cycle();
        cycle();
        chk("ready_after_rst", s_ready, 1);

        // 0xA5 waveform pinned literally
        data_valid = 1'b1;
        data_in    = 8'hA5;
        cycle();
        data_valid = 1'b0;
`ifdef UART_TX_FIFO_EN
        cycle();
`endif
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("a5_bit%0d", i), s_sig, exp_a5[i]);
            chk($sformatf("a5_done%0d", i), s_done, i == 9);
        end
        cycle();
        chk("a5_busy_after", s_busy, 0);

        // 0xFF then 0x00: frame period shows the idle gap (or lack of it)
        feed = 1'b1;
        tx_q = '{8'hFF, 8'h00};
        wait_frame(b1, s1);
        wait_frame(b2, s2);
        chk("ff_byte", b1, 8'hFF);
        chk("00_byte", b2, 8'h00);
        chk("frame_period", s2 - s1, EXP_PERIOD);

        // valid held with data_in churning while not ready
        churn = 1'b1;
        tx_q  = '{8'h5A, 8'h6B};
        wait_frame(b1, s1);
        wait_frame(b2, s2);
        chk("churn_byte0", b1, 8'h5A);
        chk("churn_byte1", b2, 8'h6B);
        churn = 1'b0;

        // reset during data bit 4 of 0x3C
        feed       = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'h3C;
        cycle();
        data_valid = 1'b0;
`ifdef UART_TX_FIFO_EN
        cycle();
`endif
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        chk("bit4_of_3c", s_sig, 1);
        reset = 1'b0;
        cycle();
        chk("midrst_signal", s_sig, 1);
        chk("midrst_busy",   s_busy, 0);
        chk("midrst_done",   s_done, 0);
        chk("midrst_ready",  s_ready, 0);
        cycle();
        chk("midrst_ready_next", s_ready, 1);
        feed = 1'b1;
        tx_q = '{8'h81};
        wait_frame(b1, s1);
        chk("after_rst_byte", b1, 8'h81);

        // five back-to-back bytes, order preserved
        ready_low_seen = 1'b0;
        tx_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 5; i++) begin
            wait_frame(b1, s1);
            chk($sformatf("burst_byte%0d", i), b1, 8'(8'h11 + i));
        end
        chk("burst_ready_drop", ready_low_seen, 1);

        // randomized traffic with occasional reset
        feed = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            data_valid = ($urandom_range(0, 2) != 0);
            data_in    = 8'($urandom);
            reset      = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        repeat (60) cycle();

        // loopback receiver agrees with the model frame-for-frame
        chk("rx_frame_count", rx_q.size(), m_frames);
        chk("rx_frames_min6", rx_q.size() >= 6, 1);
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), rx_q[i], m_sent[i]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: data_in  input  8  byte to transmit; sampled only on an accept cycle.
REQ-004 SHALL provide port: data_valid  input  1  upstream offers data_in this cycle.
REQ-005 SHALL provide port: data_ready  output  1  block can accept a byte this cycle.
REQ-006 SHALL provide port: signal  output  1  serial line; idle high; registered.
REQ-007 SHALL provide port: busy  output  1  high while a frame is on the line.
REQ-008 SHALL provide port: frame_done  output  1  one-cycle pulse, high during the stop-bit cycle.

Function
REQ-009 SHALL treat a byte as accepted at rising edge k when data_valid and data_ready are both high in the preceding cycle.
REQ-010 SHALL send each frame at one bit per clk cycle: start bit 0, 8 data bits LSB first, then stop bit 1; 10 cycles per frame.
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP, with a 3-bit counter indexing data bits 0..7 in DATA.
REQ-012 SHALL transition IDLE->START on a byte available, START->DATA after 1 cycle, DATA->STOP after bit 7, and STOP->IDLE or STOP->START (per REQ-021).
REQ-013 SHALL drive signal=1 in IDLE and STOP, 0 in START, and the indexed data bit in DATA.
REQ-014 SHALL drive busy high in START, DATA and STOP, and low in IDLE.
REQ-015 SHALL drive frame_done high only during the STOP cycle.
REQ-016 SHALL latch the byte into a shift/hold register at accept; later changes to data_in SHALL NOT affect the frame in flight.
REQ-017 SHALL derive data_ready from registered state only, with no combinational path from data_valid.
REQ-018 SHALL ignore data_valid while data_ready is low; the byte is not consumed and no frame starts.

Reset
REQ-019 SHALL, while reset is high at a clock edge, force the following on the next cycle: state=IDLE, signal=1, busy=0, frame_done=0, data_ready=0, bit counter=0, any buffered bytes discarded.
REQ-020 SHALL, on reset asserted mid-frame, abort the frame with no frame_done pulse; data_ready SHALL be high in the first cycle after reset deasserts.

Configuration
REQ-021 SHALL, without UART_TX_FIFO_EN defined, behave as follows:
- single hold register.
- data_ready=1 only in IDLE.
- start bit appears at cycle k+1 after accept at edge k.
- minimum one IDLE cycle (signal=1) between consecutive frames; 11-cycle frame period.
REQ-022 SHALL, with UART_TX_FIFO_EN defined, behave as follows:
- add a 4-entry FIFO in front of the FSM.
- data_ready = FIFO not full, from the registered count.
- pop on IDLE, or on the final STOP cycle, when non-empty.
- start bit at k+2 when idle and empty.
- back-to-back frames with no idle gap; 10-cycle frame period.
REQ-023 SHALL, with UART_TX_FIFO_EN defined, allow simultaneous push and pop in one cycle with the count unchanged; a push while full is impossible because data_ready is low.
REQ-024 SHALL, with UART_TX_FIFO_EN defined, handle wrap-around of the 2-bit read/write pointers without data loss or reorder.

Verification
REQ-025 SHALL cover: reset, then accept 0xA5 -> signal = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; frame_done high on the 10th cycle; busy low afterwards.
REQ-026 SHALL cover: accept 0xFF, then 0x00 -> frames 0,1x8,1 and 0,0x8,1; FIFO off: one idle cycle between frames; FIFO on: no idle gap.
REQ-027 SHALL cover: data_valid held high with data_in changing every cycle during a frame, FIFO off -> data_ready=0 throughout, transmitted byte equals the one captured at accept.
REQ-028 SHALL cover: reset at data bit 4 of 0x3C -> next cycle signal=1, busy=0, no frame_done pulse; a following 0x81 transmits correctly.
REQ-029 SHALL cover (FIFO on): push 5 bytes 0x11..0x15 back-to-back -> data_ready drops after 4 are buffered, all 5 are transmitted in order, and the pointers wrap.
REQ-030 SHALL cover: loopback of signal into the team's UART receiver FSM -> its valid asserts once per frame for 6 frames with no spurious assertions.
